// File: rtl/sram_mem_controller.sv
// sram_mem_controller: runs EX/MEM loads and stores as two halfword phases on a 16-bit SRAM
// Ports: clk, rst (sync, active-high); rd_en/wr_en/address/write_data come from EX/MEM;
// read_data is the registered load result; ready=0 freezes the pipeline;
// SRAM_ADDR/SRAM_DQ/SRAM_WE_N form the external halfword SRAM interface.
module sram_mem_controller #(
  parameter int BASE_ADDR    = 1024,
  parameter int PHASE_CYCLES = 3,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] data_q, data_d, rdata_q, rdata_d, off_in;
  logic last, active, dq_en;
  logic [15:0] dq_out;
  logic unused_ok;
  // Offset is taken at latch time; bits above 18 wrap within the SRAM.
  assign off_in = address - 32'(BASE_ADDR);
  assign unused_ok = ^{off_in[31:19], off_in[1:0]};
  assign last = cnt_q == LAST;
  assign active = state_q == LOW || state_q == HIGH;
  assign dq_en = active && wr_q;
  assign dq_out = state_q == HIGH ? data_q[31:16] : data_q[15:0];
  assign SRAM_DQ = dq_en ? dq_out : 16'hzzzz;
  assign SRAM_ADDR = active ? {word_q, state_q == HIGH} : 18'd0;
  // Strobe releases on the last cycle of each phase so address/data hold past the write.
  assign SRAM_WE_N = !(dq_en && !last);
  assign ready = state_q == DONE || (state_q == IDLE && !(rd_en || wr_en));
  assign read_data = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    word_d = word_q;
    data_d = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (rd_en || wr_en) begin
        wr_d = wr_en;
        word_d = off_in[18:2];
        data_d = write_data;
        cnt_d = '0;
        state_d = LOW;
      end
      LOW, HIGH: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = state_q == LOW ? HIGH : DONE;
        if (last && !wr_q && state_q == LOW) rdata_d[15:0] = SRAM_DQ;
        if (last && !wr_q && state_q == HIGH) rdata_d[31:16] = SRAM_DQ;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      word_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      word_q <= word_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences memory-stage loads/stores from the EX/MEM pipeline register onto a 16-bit external SRAM.
- Splits each 32-bit word access into two halfword phases with programmable wait states.
- Drives `ready`; while `ready`=0 the pipeline registers (EX/MEM included) and earlier stages are frozen.
- Sits between the EX/MEM register outputs (ALU result as address, Rm value as store data, mem read/write enables) and the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; offset = address - BASE_ADDR.
- PHASE_CYCLES, 3: cycles per halfword phase; legal range >= 2.
- CNT_W, 3: width of the wait-state counter; must hold PHASE_CYCLES-1.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request (mem_read from EX/MEM).
- wr_en  in  1  store request (mem_write from EX/MEM).
- address  in  32  byte address (ALU result); word aligned.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result, registered.
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- SRAM_ADDR  out  18  halfword address.
- SRAM_DQ  inout  16  data bus; high-Z unless writing.
- SRAM_WE_N  out  1  active-low write strobe.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, LOW, HIGH, DONE. A counter `cnt` (CNT_W bits) runs within LOW/HIGH.
- Reset (sampled on a clk edge):
  - state=IDLE, cnt=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - Applies from any state, including mid-access; a partial access is abandoned and is not resumed.
- IDLE:
  - ready = !(rd_en | wr_en), combinational.
  - On a request: latch op, address and write_data internally; cnt=0; go to LOW.
  - Inputs changing after the latch are ignored until the next IDLE.
  - If wr_en and rd_en are both 1, the access is a write; read_data is unchanged.
- Address mapping:
  - word = (latched address - BASE_ADDR)[18:2].
  - SRAM_ADDR = {word, 0} in LOW and {word, 1} in HIGH.
  - SRAM_ADDR = 0 in IDLE and DONE.
- LOW and HIGH phases (each exactly PHASE_CYCLES cycles):
  - cnt counts 0..PHASE_CYCLES-1.
  - On cnt=PHASE_CYCLES-1: LOW advances to HIGH, HIGH advances to DONE; cnt resets to 0.
- Write phases:
  - SRAM_DQ driven with data[15:0] in LOW and data[31:16] in HIGH, on every cycle of the phase.
  - SRAM_WE_N=0 while cnt < PHASE_CYCLES-1, and 1 on the last cycle of each phase (address/data hold).
- Read phases:
  - SRAM_WE_N=1 and SRAM_DQ=Z throughout.
  - On the last cycle of LOW, read_data[15:0] <= SRAM_DQ; on the last cycle of HIGH, read_data[31:16] <= SRAM_DQ.
  - The other half of read_data holds its value.
- ready = 0 in LOW and HIGH.
- DONE:
  - ready=1 for exactly one cycle, SRAM_WE_N=1, DQ=Z; unconditionally go to IDLE.
  - The still-asserted request in the DONE cycle does not restart an access.
  - The pipeline advances on this edge, so IDLE sees the next instruction's request.
- Latency: a request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..2*PHASE_CYCLES and ready=1 in cycle 2*PHASE_CYCLES+1 (DONE).
  - With default PHASE_CYCLES=3: 7 stall cycles, then ready in the 8th cycle.
  - read_data is valid from the DONE cycle on and holds until the next read capture or reset.
- Back-to-back accesses: DONE->IDLE->LOW. Each access pays the full latency; there is no overlap.
- Address arithmetic: the upper bits of the subtraction beyond bit 18 are discarded (wrap within the SRAM); no range check.

Test Plan:
- Idle, rd_en=wr_en=0 for 10 cycles -> ready=1 every cycle, SRAM_WE_N=1, DQ=Z, read_data=0.
- Store wr_en=1, address=1028, write_data=0xDEADBEEF -> ready=0 cycles 0..6. SRAM_ADDR=2 with DQ=0xBEEF in cycles 1..3, SRAM_ADDR=3 with DQ=0xDEAD in cycles 4..6. WE_N=0 in cycles 1,2,4,5 and 1 in cycles 3,6. ready=1 in cycle 7. SRAM model word 1 = 0xDEADBEEF.
- Load rd_en=1, address=1028 after the store -> WE_N stays 1; read_data=0xDEADBEEF in cycle 7 and held while rd_en later drops; a second read of 1024 (model holds 0x12345678) -> read_data=0x12345678.
- rd_en=wr_en=1 together, address=1032, data=0x0000CAFE -> write performed (SRAM_ADDR 4/5 written with 0xCAFE/0x0000); read_data unchanged.
- Request held high continuously across two accesses -> exactly two accesses; the DONE cycle does not retrigger; second access starts the cycle after DONE; address changed mid-access is ignored.
- rst=1 during HIGH of a write -> next cycle state IDLE, WE_N=1, DQ=Z, read_data=0, ready=1 with rd_en=wr_en=0; a following read completes normally in 8 cycles.
